// File: rtl/cnt_seg7_scan.sv
// Two-digit common-anode 7-segment scanner for a 4-bit counter value (0..15).
// Optional build macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module cnt_seg7_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] CNT,
  input  logic       CNT_VLD,
  output logic [6:0] SEG,
  output logic [1:0] DIG
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic [3:0]    val_q, val_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic          dig_sel_q, dig_sel_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;

  logic          tens;
  logic [3:0]    ones;
  logic [3:0]    digit_val;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    tens      = (val_q >= 4'd10);
    ones      = val_q - (tens ? 4'd10 : 4'd0);
    digit_val = dig_sel_q ? {3'b000, tens} : ones;
  end

  always_comb begin
    val_d      = CNT_VLD ? CNT : val_q;
    scan_cnt_d = scan_cnt_q + 1'b1;
    dig_sel_d  = dig_sel_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      dig_sel_d  = ~dig_sel_q;
    end
    // Display uses this cycle's digit select and value so DIG and SEG move together.
    dig_d = dig_sel_q ? 2'b01 : 2'b10;
`ifdef LEADING_ZERO_BLANK_EN
    seg_d = (dig_sel_q && !tens) ? 7'h7F : decode(digit_val);
`else
    seg_d = decode(digit_val);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      val_q      <= '0;
      scan_cnt_q <= '0;
      dig_sel_q  <= 1'b0;
      seg_q      <= 7'h7F;
      dig_q      <= 2'b11;
    end else begin
      val_q      <= val_d;
      scan_cnt_q <= scan_cnt_d;
      dig_sel_q  <= dig_sel_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign SEG = seg_q;
  assign DIG = dig_q;

endmodule

// File: tb/tb_cnt_seg7_scan.sv
// Directed bench for cnt_seg7_scan with SCAN_DIV=4; honours LEADING_ZERO_BLANK_EN.
module tb_cnt_seg7_scan;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TZ = 7'h7F;
`else
  localparam logic [6:0] TZ = 7'h40;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt = 4'd0;
  logic       cnt_vld = 1'b0;
  logic [6:0] seg;
  logic [1:0] dig;

  int total_cnt = 0;
  int pass_cnt  = 0;

  cnt_seg7_scan #(.SCAN_DIV(4)) dut (
    .CLK(clk), .RST(rst), .CNT(cnt), .CNT_VLD(cnt_vld), .SEG(seg), .DIG(dig)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are observed 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; cnt_vld = 1'b0;
    ticks(2);
    rst = 1'b0;
  endtask

  // Loads v so that it is latched at the next edge.
  task automatic load_tick(input logic [3:0] v);
    cnt = v; cnt_vld = 1'b1;
    tick();
    cnt_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cnt_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({dig, seg} !== {2'b11, 7'h7F})
        $display("FAIL reset_hold[%0d] dig=%b seg=%h want dig=11 seg=7f", i, dig, seg);
      else pass_cnt++;
    end
    rst = 1'b0;
    tick();
    total_cnt++;
    if ({dig, seg} !== {2'b10, 7'h40})
      $display("FAIL reset_release dig=%b seg=%h want dig=10 seg=40", dig, seg);
    else pass_cnt++;
  endtask

  task automatic test_load();
    do_reset();
    load_tick(4'd7);                 // e1: latch 7, display still 0
    tick();                          // e2
    total_cnt++;
    if ({dig, seg} !== {2'b10, 7'h78})
      $display("FAIL load_ones dig=%b seg=%h want dig=10 seg=78", dig, seg);
    else pass_cnt++;
    cnt = 4'd3;                      // ignored, strobe low
    ticks(3);                        // e5: tens slot
    total_cnt++;
    if ({dig, seg} !== {2'b01, TZ})
      $display("FAIL load_tens dig=%b seg=%h want dig=01 seg=%h", dig, seg, TZ);
    else pass_cnt++;
  endtask

  task automatic test_scan_timing();
    logic [1:0] exp_dig;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_dig = ((i / 4) % 2 == 0) ? 2'b10 : 2'b01;
      total_cnt++;
      if (dig !== exp_dig)
        $display("FAIL scan_edge[%0d] dig=%b want %b", i + 1, dig, exp_dig);
      else pass_cnt++;
    end
  endtask

  task automatic test_two_digit();
    do_reset();
    load_tick(4'd12);                // e1
    tick();                          // e2
    total_cnt++;
    if ({dig, seg} !== {2'b10, 7'h24})
      $display("FAIL two12_ones dig=%b seg=%h want dig=10 seg=24", dig, seg);
    else pass_cnt++;
    ticks(3);                        // e5
    total_cnt++;
    if ({dig, seg} !== {2'b01, 7'h79})
      $display("FAIL two12_tens dig=%b seg=%h want dig=01 seg=79", dig, seg);
    else pass_cnt++;
    load_tick(4'd15);                // e6
    ticks(3);                        // e9: ones slot
    total_cnt++;
    if ({dig, seg} !== {2'b10, 7'h12})
      $display("FAIL two15_ones dig=%b seg=%h want dig=10 seg=12", dig, seg);
    else pass_cnt++;
    ticks(4);                        // e13: tens slot
    total_cnt++;
    if ({dig, seg} !== {2'b01, 7'h79})
      $display("FAIL two15_tens dig=%b seg=%h want dig=01 seg=79", dig, seg);
    else pass_cnt++;
    ticks(2);                        // e15
    load_tick(4'd3);                 // e16: load coincides with tens->ones toggle
    total_cnt++;
    if ({dig, seg} !== {2'b01, 7'h79})
      $display("FAIL coincide_old dig=%b seg=%h want dig=01 seg=79", dig, seg);
    else pass_cnt++;
    tick();                          // e17
    total_cnt++;
    if ({dig, seg} !== {2'b10, 7'h30})
      $display("FAIL coincide_new dig=%b seg=%h want dig=10 seg=30", dig, seg);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    load_tick(4'd12);                // e1
    ticks(4);                        // e5
    total_cnt++;
    if ({dig, seg} !== {2'b01, 7'h79})
      $display("FAIL wrap12_tens dig=%b seg=%h want dig=01 seg=79", dig, seg);
    else pass_cnt++;
    load_tick(4'd0);                 // e6
    tick();                          // e7
    total_cnt++;
    if ({dig, seg} !== {2'b01, TZ})
      $display("FAIL wrap0_tens dig=%b seg=%h want dig=01 seg=%h", dig, seg, TZ);
    else pass_cnt++;
    ticks(2);                        // e9
    total_cnt++;
    if ({dig, seg} !== {2'b10, 7'h40})
      $display("FAIL wrap0_ones dig=%b seg=%h want dig=10 seg=40", dig, seg);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_tick(4'd9);                 // e1
    ticks(4);                        // e5: tens slot
    total_cnt++;
    if ({dig, seg} !== {2'b01, TZ})
      $display("FAIL mid_tens dig=%b seg=%h want dig=01 seg=%h", dig, seg, TZ);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({dig, seg} !== {2'b11, 7'h7F})
      $display("FAIL mid_reset dig=%b seg=%h want dig=11 seg=7f", dig, seg);
    else pass_cnt++;
    rst = 1'b0;
    tick();                          // e1 after restart: value cleared
    total_cnt++;
    if ({dig, seg} !== {2'b10, 7'h40})
      $display("FAIL mid_restart dig=%b seg=%h want dig=10 seg=40", dig, seg);
    else pass_cnt++;
    ticks(3);                        // e4: still ones
    total_cnt++;
    if (dig !== 2'b10)
      $display("FAIL mid_slot_end dig=%b want 10", dig);
    else pass_cnt++;
    tick();                          // e5
    total_cnt++;
    if (dig !== 2'b01)
      $display("FAIL mid_slot_next dig=%b want 01", dig);
    else pass_cnt++;
  endtask

  task automatic test_hold_priority();
    do_reset();
    load_tick(4'd5);                 // e1
    tick();                          // e2
    total_cnt++;
    if ({dig, seg} !== {2'b10, 7'h12})
      $display("FAIL hold_load dig=%b seg=%h want dig=10 seg=12", dig, seg);
    else pass_cnt++;
    cnt = 4'd8;
    ticks(2);                        // e4
    total_cnt++;
    if ({dig, seg} !== {2'b10, 7'h12})
      $display("FAIL hold_ignore dig=%b seg=%h want dig=10 seg=12", dig, seg);
    else pass_cnt++;
    rst = 1'b1; cnt = 4'd8; cnt_vld = 1'b1;
    tick();
    total_cnt++;
    if ({dig, seg} !== {2'b11, 7'h7F})
      $display("FAIL prio_reset dig=%b seg=%h want dig=11 seg=7f", dig, seg);
    else pass_cnt++;
    rst = 1'b0; cnt_vld = 1'b0;
    tick();
    total_cnt++;
    if ({dig, seg} !== {2'b10, 7'h40})
      $display("FAIL prio_cleared dig=%b seg=%h want dig=10 seg=40", dig, seg);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_scan_timing();
    test_two_digit();
    test_wrap();
    test_reset_mid();
    test_hold_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
